// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : RV32I decode/issue stage. Turns OP, OP-IMM, LUI and AUIPC
//               instructions into registered ALU operation and operands, with
//               operand forwarding from the ALU and writeback stages.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_fwd_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [3:0]      op_val,
  output logic            signed_unsigned_n,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal_instr
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [3:0] ALU_NOP    = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0001;
  localparam logic [3:0] ALU_SUB    = 4'b0010;
  localparam logic [3:0] ALU_SLT    = 4'b0011;
  localparam logic [3:0] ALU_SLTU   = 4'b1011;
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_OR     = 4'b0101;
  localparam logic [3:0] ALU_XOR    = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;

  // Instruction fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt_i;

  // Resolved operands and decode results
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_shamt_r;
  logic [3:0]      w_op;
  logic            w_signed;
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic            w_legal;

  // ALU-stage entry
  logic [3:0]      r_op;
  logic            r_signed;
  logic [XLEN-1:0] r_opa;
  logic [XLEN-1:0] r_opb;
  logic [4:0]      r_rd;
  logic            r_rd_we;
  logic            r_illegal;

  assign w_opcode  = instr[6:0];
  assign w_rd      = instr[11:7];
  assign w_funct3  = instr[14:12];
  assign w_funct7  = instr[31:25];
  assign rs1_addr  = instr[19:15];
  assign rs2_addr  = instr[24:20];

  assign w_imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_u   = {instr[31:12], 12'b0};
  assign w_shamt_i = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Forwarding priority: x0, then the ALU-stage entry, then writeback, then RF.
  function automatic logic [XLEN-1:0] f_resolve(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_val,
    input logic            alu_we,
    input logic [4:0]      alu_rd,
    input logic [XLEN-1:0] alu_val,
    input logic            wbk_we,
    input logic [4:0]      wbk_rd,
    input logic [XLEN-1:0] wbk_val
  );
    logic [XLEN-1:0] v;
    if (rs == 5'd0)
      v = '0;
    else if (alu_we && (alu_rd == rs))
      v = alu_val;
    else if (wbk_we && (wbk_rd == rs))
      v = wbk_val;
    else
      v = rf_val;
    return v;
  endfunction

  assign w_rs1_val = f_resolve(rs1_addr, rs1_data, r_rd_we, r_rd, alu_fwd_data,
                               wb_we, wb_rd, wb_data);
  assign w_rs2_val = f_resolve(rs2_addr, rs2_data, r_rd_we, r_rd, alu_fwd_data,
                               wb_we, wb_rd, wb_data);
  assign w_shamt_r = {{(XLEN-5){1'b0}}, w_rs2_val[4:0]};

  always_comb begin
    w_op     = ALU_NOP;
    w_signed = 1'b0;
    w_opa    = '0;
    w_opb    = '0;
    w_legal  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_opa = w_rs1_val;
        w_opb = w_rs2_val;
        if (w_funct7 == F7_BASE) begin
          w_legal = 1'b1;
          case (w_funct3)
            3'b000: w_op = ALU_ADD;
            3'b001: begin w_op = ALU_SLL; w_opb = w_shamt_r; end
            3'b010: begin w_op = ALU_SLT; w_signed = 1'b1; end
            3'b011: w_op = ALU_SLTU;
            3'b100: w_op = ALU_XOR;
            3'b101: begin w_op = ALU_SRL; w_opb = w_shamt_r; end
            3'b110: w_op = ALU_OR;
            default: w_op = ALU_AND;
          endcase
        end else if (w_funct7 == F7_ALT) begin
          if (w_funct3 == 3'b000) begin
            w_legal = 1'b1;
            w_op    = ALU_SUB;
          end else if (w_funct3 == 3'b101) begin
            w_legal  = 1'b1;
            w_op     = ALU_SRA;
            w_signed = 1'b1;
            w_opb    = w_shamt_r;
          end
        end
      end
      OPC_OP_IMM: begin
        w_opa   = w_rs1_val;
        w_opb   = w_imm_i;
        w_legal = 1'b1;
        case (w_funct3)
          3'b000: w_op = ALU_ADD;
          3'b010: begin w_op = ALU_SLT; w_signed = 1'b1; end
          3'b011: w_op = ALU_SLTU;
          3'b100: w_op = ALU_XOR;
          3'b110: w_op = ALU_OR;
          3'b111: w_op = ALU_AND;
          3'b001: begin
            w_op    = ALU_SLL;
            w_opb   = w_shamt_i;
            w_legal = (w_funct7 == F7_BASE);
          end
          default: begin
            // funct3 101: the funct7 field picks logical vs arithmetic shift
            w_opb = w_shamt_i;
            if (w_funct7 == F7_BASE) begin
              w_op = ALU_SRL;
            end else if (w_funct7 == F7_ALT) begin
              w_op     = ALU_SRA;
              w_signed = 1'b1;
            end else begin
              w_legal = 1'b0;
            end
          end
        endcase
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_op    = ALU_ADD;
        w_opb   = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_op    = ALU_ADD;
        w_opa   = pc;
        w_opb   = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Halt freezes the whole entry, so a pending illegal flag is held, not re-pulsed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= ALU_NOP;
      r_signed  <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_rd      <= 5'd0;
      r_rd_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!halt) begin
      if (instr_valid && w_legal) begin
        r_op      <= w_op;
        r_signed  <= w_signed;
        r_opa     <= w_opa;
        r_opb     <= w_opb;
        r_rd      <= w_rd;
        r_rd_we   <= 1'b1;
        r_illegal <= 1'b0;
      end else begin
        r_op      <= ALU_NOP;
        r_signed  <= 1'b0;
        r_opa     <= '0;
        r_opb     <= '0;
        r_rd      <= 5'd0;
        r_rd_we   <= 1'b0;
        r_illegal <= instr_valid;
      end
    end
  end

  assign op_val            = r_op;
  assign signed_unsigned_n = r_signed;
  assign operand_a         = r_opa;
  assign operand_b         = r_opb;
  assign rd_addr           = r_rd;
  assign rd_we             = r_rd_we;
  assign illegal_instr     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Scoreboard bench for alu_issue: directed and random stimulus
//               against a reference model of the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  typedef struct packed {
    logic [3:0]  op;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, halt, instr_valid;
  logic [31:0] instr, pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, alu_fwd_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  op_val;
  logic        signed_unsigned_n;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_addr;
  logic        rd_we, illegal_instr;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t prev = '0;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_fwd_data(alu_fwd_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .op_val(op_val),
    .signed_unsigned_n(signed_unsigned_n), .operand_a(operand_a),
    .operand_b(operand_b), .rd_addr(rd_addr), .rd_we(rd_we),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return 32'd0;
    if (prev.we && prev.rd == rs) return alu_fwd_data;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  // What the ALU should be asked to do for one valid instruction.
  function automatic exp_t model_issue(input logic [31:0] ins, input logic [31:0] pcv,
                                       input logic [31:0] a1, input logic [31:0] a2);
    exp_t e;
    logic legal;
    logic [9:0]  key;
    logic [31:0] imm;
    e     = '0;
    legal = 1'b1;
    key   = {ins[31:25], ins[14:12]};
    imm   = {{20{ins[31]}}, ins[31:20]};
    case (ins[6:0])
      7'h37: begin e.op = 4'd1; e.a = 0;   e.b = {ins[31:12], 12'h000}; end
      7'h17: begin e.op = 4'd1; e.a = pcv; e.b = {ins[31:12], 12'h000}; end
      7'h33: begin
        e.a = a1; e.b = a2;
        case (key)
          {7'h00, 3'd0}: e.op = 4'd1;
          {7'h20, 3'd0}: e.op = 4'd2;
          {7'h00, 3'd1}: begin e.op = 4'd7; e.b = a2 % 32; end
          {7'h00, 3'd2}: e.op = 4'd3;
          {7'h00, 3'd3}: e.op = 4'd11;
          {7'h00, 3'd4}: e.op = 4'd6;
          {7'h00, 3'd5}: begin e.op = 4'd8; e.b = a2 % 32; end
          {7'h20, 3'd5}: begin e.op = 4'd9; e.b = a2 % 32; end
          {7'h00, 3'd6}: e.op = 4'd5;
          {7'h00, 3'd7}: e.op = 4'd4;
          default: legal = 1'b0;
        endcase
      end
      7'h13: begin
        e.a = a1; e.b = imm;
        case (ins[14:12])
          3'd0: e.op = 4'd1;
          3'd2: e.op = 4'd3;
          3'd3: e.op = 4'd11;
          3'd4: e.op = 4'd6;
          3'd6: e.op = 4'd5;
          3'd7: e.op = 4'd4;
          3'd1: begin e.op = 4'd7; e.b = ins[24:20]; legal = (ins[31:25] == 0); end
          default: begin
            e.b = ins[24:20];
            if (ins[31:25] == 7'h00) e.op = 4'd8;
            else if (ins[31:25] == 7'h20) e.op = 4'd9;
            else legal = 1'b0;
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '0;
      e.ill = 1'b1;
    end else begin
      e.sg = (e.op == 4'd3) || (e.op == 4'd9);
      e.rd = ins[11:7];
      e.we = 1'b1;
    end
    return e;
  endfunction

  // Inputs are already set by the caller; predict the next-edge outputs.
  task automatic step();
    exp_t e;
    #1;
    checks++;
    if (rs1_addr !== instr[19:15] || rs2_addr !== instr[24:20]) begin
      errors++;
      $display("FAIL rs_addr: got %0d/%0d, expected %0d/%0d",
               rs1_addr, rs2_addr, instr[19:15], instr[24:20]);
    end
    if (!rst_n) e = '0;
    else if (halt) e = prev;
    else if (!instr_valid) e = '0;
    else e = model_issue(instr, pc, resolve(instr[19:15], rs1_data),
                         resolve(instr[24:20], rs2_data));
    prev = e;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1; halt = 0; instr_valid = 1; wb_we = 0; wb_rd = 0; wb_data = 0;
    pc = 32'h100; rs1_data = 0; rs2_data = 0; alu_fwd_data = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int kind;
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    rd   = 5'($urandom_range(0, 7));
    f3   = 3'($urandom_range(0, 7));
    imm  = 12'($urandom);
    w    = $urandom;
    kind = $urandom_range(0, 9);
    f7   = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 9) == 0) f7 = 7'($urandom);
    if (kind <= 3) return enc_r(f7, rs2, rs1, f3, rd);
    if (kind <= 6) begin
      if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
      return enc_i(imm, rs1, f3, rd);
    end
    if (kind == 7) return {w[31:12], rd, 7'h37};
    if (kind == 8) return {w[31:12], rd, 7'h17};
    return w;
  endfunction

  // Monitor: one registered result per clock edge, in issue order.
  initial begin
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {op_val, signed_unsigned_n, operand_a, operand_b, rd_addr, rd_we, illegal_instr};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL issue: got op=%h s=%b a=%h b=%h rd=%0d we=%b ill=%b, expected op=%h s=%b a=%h b=%h rd=%0d we=%b ill=%b",
                   act.op, act.sg, act.a, act.b, act.rd, act.we, act.ill,
                   e.op, e.sg, e.a, e.b, e.rd, e.we, e.ill);
        end
      end
    end
  end

  initial begin
    idle();
    rst_n = 0; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); step();
    rst_n = 0; step();
    idle();

    instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3); rs1_data = 5; rs2_data = 7; step();
    instr = 32'hFFF00093; step();
    instr = enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd2); alu_fwd_data = 32'hFFFF_FFFF; step();
    instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5); alu_fwd_data = 0; step();
    instr = enc_r(7'h20, 5'd5, 5'd5, 3'd0, 5'd6);
    alu_fwd_data = 32'h10; rs1_data = 32'hDEAD; rs2_data = 32'hBEEF; step();
    instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0); step();
    instr = enc_r(7'h20, 5'd0, 5'd0, 3'd0, 5'd6); step();
    instr = enc_r(7'h00, 5'd7, 5'd7, 3'd6, 5'd8);
    wb_we = 1; wb_rd = 7; wb_data = 32'h55; alu_fwd_data = 32'h99; step();
    instr = enc_r(7'h00, 5'd8, 5'd8, 3'd6, 5'd9);
    wb_rd = 8; wb_data = 32'h66; alu_fwd_data = 32'h77; step();
    idle();

    instr = 32'h0000_007F; step();
    instr = enc_r(7'h20, 5'd1, 5'd2, 3'd4, 5'd3); step();
    halt = 1; instr = enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd3); step(); step();
    halt = 0; step();
    instr = enc_r(7'h00, 5'd3, 5'd1, 3'd1, 5'd4); rs2_data = 32'hFFFF_FF23; step();
    halt = 1;
    for (int i = 0; i < 3; i++) begin instr = $urandom; rs1_data = $urandom; step(); end
    rst_n = 0; step();
    idle();
    instr = {20'h12345, 5'd1, 7'h37}; step();
    instr = {20'hABCDE, 5'd2, 7'h17}; pc = 32'h1000; step();

    for (int i = 0; i < 600; i++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      halt         = ($urandom_range(0, 9) == 0);
      instr_valid  = ($urandom_range(0, 7) != 0);
      instr        = rand_instr();
      pc           = $urandom;
      rs1_data     = $urandom;
      rs2_data     = $urandom;
      alu_fwd_data = $urandom;
      wb_we        = ($urandom_range(0, 1) == 1);
      wb_rd        = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      step();
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
